// File: rtl/bank_stats_pkg.sv
// Shared widths, tag-table entry layout and saturating accumulate helper
// for the per-bank request latency tracker.
package bank_stats_pkg;

  localparam int REQ_ID_W = 32;
  localparam int ADDR_W   = 32;
  localparam int CYCLE_W  = 64;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
    logic [CYCLE_W-1:0]  issue_cycle;
    logic [ADDR_W-1:0]   addr;
  } lat_entry_t;

  function automatic logic [CYCLE_W-1:0] sat_add(input logic [CYCLE_W-1:0] a,
                                                 input logic [CYCLE_W-1:0] b);
    logic [CYCLE_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CYCLE_W] ? {CYCLE_W{1'b1}} : s[CYCLE_W-1:0];
  endfunction

endpackage

// File: rtl/bank_latency_tag_table.sv
// Outstanding-request tag table: lowest-free allocation, CAM lookup with
// lowest-hit priority, and occupancy counter. Lookup sees pre-cycle contents.
module bank_latency_tag_table
  import bank_stats_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_fire,
  input  logic [REQ_ID_W-1:0] req_id,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [CYCLE_W-1:0]  req_cycle,
  input  logic                resp_fire,
  input  logic [REQ_ID_W-1:0] resp_id,
  output logic                hit,
  output logic [CYCLE_W-1:0]  hit_issue_cycle,
  output logic [ADDR_W-1:0]   hit_addr,
  output logic                full,
  output logic                drop,
  output logic [CNT_W-1:0]    count
);

  lat_entry_t       entry_reg [DEPTH];
  logic [DEPTH-1:0] match_vec;
  logic [DEPTH-1:0] free_vec;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] hit_idx;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             alloc;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam
    assign match_vec[gi] = entry_reg[gi].valid && (entry_reg[gi].id == resp_id);
    assign free_vec[gi]  = !entry_reg[gi].valid;
  end

  // Descending scan so the lowest set index is the last one written.
  always_comb begin
    free_idx = '0;
    hit_idx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (free_vec[i])  free_idx = IDX_W'(i);
      if (match_vec[i]) hit_idx  = IDX_W'(i);
    end
  end

  assign full            = (count_reg == CNT_W'(DEPTH));
  assign alloc           = req_fire && !full;
  assign drop            = req_fire && full;
  assign hit             = resp_fire && (|match_vec);
  assign hit_issue_cycle = entry_reg[hit_idx].issue_cycle;
  assign hit_addr        = entry_reg[hit_idx].addr;
  assign count           = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({alloc, hit})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // A free slot and a hit slot are never the same entry, so both may act at once.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset) begin
        entry_reg[i].valid <= 1'b0;
      end else if (alloc && free_idx == IDX_W'(i)) begin
        entry_reg[i] <= '{valid: 1'b1, id: req_id, issue_cycle: req_cycle, addr: req_addr};
      end else if (hit && hit_idx == IDX_W'(i)) begin
        entry_reg[i].valid <= 1'b0;
      end
    end
    if (!reset) count_reg <= '0;
    else        count_reg <= count_next;
  end

endmodule

// File: rtl/bank_request_latency_tracker.sv
// Per-bank request latency tracker: matches responses to requests and keeps
// running latency statistics. Define BANK_LATENCY_TRACE_EN for a CSV trace.
module bank_request_latency_tracker
  import bank_stats_pkg::*;
#(
  parameter int RANK  = 0,
  parameter int BANK  = 0,
  parameter int DEPTH = 16,
  parameter int LAT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_fire,
  input  logic [31:0]                  req_id,
  input  logic [31:0]                  req_addr,
  input  logic                         resp_fire,
  input  logic [31:0]                  resp_id,
  input  logic [63:0]                  global_cycle,
  input  logic                         stat_clear,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         table_full,
  output logic                         last_valid,
  output logic [LAT_W-1:0]             last_latency,
  output logic [LAT_W-1:0]             lat_count,
  output logic [63:0]                  lat_sum,
  output logic [LAT_W-1:0]             lat_min,
  output logic [LAT_W-1:0]             lat_max,
  output logic                         err_overflow,
  output logic                         err_orphan
);

  localparam logic [63:0] LAT_CAP = {64{1'b1}} >> (64 - LAT_W);

  logic               tbl_hit;
  logic               tbl_full;
  logic               tbl_drop;
  logic [CYCLE_W-1:0] tbl_hit_issue_cycle;
  logic [ADDR_W-1:0]  tbl_hit_addr;
  logic [63:0]        lat_diff;
  logic [LAT_W-1:0]   lat_sat;

  logic               last_valid_reg;
  logic [LAT_W-1:0]   last_latency_reg;
  logic [LAT_W-1:0]   lat_count_reg;
  logic [63:0]        lat_sum_reg;
  logic [LAT_W-1:0]   lat_min_reg;
  logic [LAT_W-1:0]   lat_max_reg;
  logic               err_overflow_reg;
  logic               err_orphan_reg;

  bank_latency_tag_table #(.DEPTH(DEPTH)) u_tag_table (
    .clk             (clk),
    .reset           (reset),
    .req_fire        (req_fire),
    .req_id          (req_id),
    .req_addr        (req_addr),
    .req_cycle       (global_cycle),
    .resp_fire       (resp_fire),
    .resp_id         (resp_id),
    .hit             (tbl_hit),
    .hit_issue_cycle (tbl_hit_issue_cycle),
    .hit_addr        (tbl_hit_addr),
    .full            (tbl_full),
    .drop            (tbl_drop),
    .count           (outstanding)
  );

  // Modular subtraction tolerates a wrapped cycle counter.
  assign lat_diff = global_cycle - tbl_hit_issue_cycle;
  assign lat_sat  = (lat_diff > LAT_CAP) ? {LAT_W{1'b1}} : lat_diff[LAT_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_valid_reg   <= 1'b0;
      last_latency_reg <= '0;
      lat_count_reg    <= '0;
      lat_sum_reg      <= '0;
      lat_min_reg      <= '1;
      lat_max_reg      <= '0;
      err_overflow_reg <= 1'b0;
      err_orphan_reg   <= 1'b0;
    end else begin
      last_valid_reg <= tbl_hit;
      if (tbl_hit) last_latency_reg <= lat_sat;
      // A clear in the same cycle as a hit discards that sample.
      if (stat_clear) begin
        lat_count_reg <= '0;
        lat_sum_reg   <= '0;
        lat_min_reg   <= '1;
        lat_max_reg   <= '0;
      end else if (tbl_hit) begin
        if (lat_count_reg != {LAT_W{1'b1}}) lat_count_reg <= lat_count_reg + 1'b1;
        lat_sum_reg <= sat_add(lat_sum_reg, 64'(lat_sat));
        if (lat_sat < lat_min_reg) lat_min_reg <= lat_sat;
        if (lat_sat > lat_max_reg) lat_max_reg <= lat_sat;
      end
      if (tbl_drop)              err_overflow_reg <= 1'b1;
      if (resp_fire && !tbl_hit) err_orphan_reg   <= 1'b1;
    end
  end

  assign table_full   = tbl_full;
  assign last_valid   = last_valid_reg;
  assign last_latency = last_latency_reg;
  assign lat_count    = lat_count_reg;
  assign lat_sum      = lat_sum_reg;
  assign lat_min      = lat_min_reg;
  assign lat_max      = lat_max_reg;
  assign err_overflow = err_overflow_reg;
  assign err_orphan   = err_orphan_reg;

`ifdef BANK_LATENCY_TRACE_EN
  initial begin
    $display("bank_latency_trace_rank%0d_bank%0d: RequestID,Address,IssueCycle,RespCycle,Latency", RANK, BANK);
  end

  always @(posedge clk) begin
    if (reset) begin
      if (tbl_hit)
        $display("bank_latency_trace_rank%0d_bank%0d: %0d,%0d,%0d,%0d,%0d", RANK, BANK,
                 resp_id, tbl_hit_addr, tbl_hit_issue_cycle, global_cycle, lat_sat);
      if (tbl_drop)
        $display("bank_latency_trace_rank%0d_bank%0d: %0d,%0d,%0d,,-1", RANK, BANK,
                 req_id, req_addr, global_cycle);
      if (resp_fire && !tbl_hit)
        $display("bank_latency_trace_rank%0d_bank%0d: %0d,,,%0d,-1", RANK, BANK,
                 resp_id, global_cycle);
    end
  end
`else
  // Address and instance indices only feed the trace.
  logic unused_trace;
  assign unused_trace = ^{tbl_hit_addr, RANK[0], BANK[0]};
`endif

endmodule

// File: tb/tb_bank_request_latency_tracker.sv
// Scoreboard bench: stimulus pushes expected latencies, a negedge monitor pops
// them on last_valid; status outputs are checked directly after each step.
module tb_bank_request_latency_tracker;

  localparam int DEPTH = 16;
  localparam int LAT_W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_fire;
  logic [31:0] req_id;
  logic [31:0] req_addr;
  logic        resp_fire;
  logic [31:0] resp_id;
  logic [63:0] global_cycle;
  logic        stat_clear;
  logic [$clog2(DEPTH+1)-1:0] outstanding;
  logic        table_full;
  logic        last_valid;
  logic [LAT_W-1:0] last_latency;
  logic [LAT_W-1:0] lat_count;
  logic [63:0] lat_sum;
  logic [LAT_W-1:0] lat_min;
  logic [LAT_W-1:0] lat_max;
  logic        err_overflow;
  logic        err_orphan;

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];

  always #5 clk = ~clk;

  bank_request_latency_tracker #(.RANK(0), .BANK(0), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_fire     (req_fire),
    .req_id       (req_id),
    .req_addr     (req_addr),
    .resp_fire    (resp_fire),
    .resp_id      (resp_id),
    .global_cycle (global_cycle),
    .stat_clear   (stat_clear),
    .outstanding  (outstanding),
    .table_full   (table_full),
    .last_valid   (last_valid),
    .last_latency (last_latency),
    .lat_count    (lat_count),
    .lat_sum      (lat_sum),
    .lat_min      (lat_min),
    .lat_max      (lat_max),
    .err_overflow (err_overflow),
    .err_orphan   (err_orphan)
  );

  // Monitor: every last_valid pulse must match the oldest expected latency.
  always @(negedge clk) begin
    if (last_valid) begin
      int unsigned e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL latency_unexpected: got last_latency=%0d with no expected response", last_latency);
      end else begin
        e = exp_q.pop_front();
        if (last_latency !== e) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d", last_latency, e);
        end else begin
          $display("response latency %0d ok", last_latency);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    global_cycle = global_cycle + 64'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic fire(input bit rq, input logic [31:0] rid, input bit rs, input logic [31:0] sid);
    req_fire  = rq;
    req_id    = rid;
    req_addr  = rid + 32'h1000;
    resp_fire = rs;
    resp_id   = sid;
    cyc();
    req_fire  = 1'b0;
    resp_fire = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  task automatic do_lat(input logic [31:0] id, input int lat);
    fire(1'b1, id, 1'b0, 32'd0);
    idle(lat - 1);
    exp_q.push_back(lat);
    fire(1'b0, 32'd0, 1'b1, id);
  endtask

  task automatic chk_stats_reset(input string tag);
    chk({tag, "_count"}, 64'(lat_count), 64'd0);
    chk({tag, "_sum"},   lat_sum, 64'd0);
    chk({tag, "_min"},   64'(lat_min), 64'hFFFF_FFFF);
    chk({tag, "_max"},   64'(lat_max), 64'd0);
  endtask

  initial begin
    reset = 1'b0; req_fire = 1'b0; req_id = '0; req_addr = '0;
    resp_fire = 1'b0; resp_id = '0; global_cycle = '0; stat_clear = 1'b0;
    do_reset();

    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_full", 64'(table_full), 64'd0);
    chk("rst_last_valid", 64'(last_valid), 64'd0);
    chk("rst_last_latency", 64'(last_latency), 64'd0);
    chk_stats_reset("rst");
    chk("rst_err_overflow", 64'(err_overflow), 64'd0);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);

    // Single request/response: issue 100, respond 112.
    global_cycle = 64'd100;
    fire(1'b1, 32'd5, 1'b0, 32'd0);
    chk("s1_outstanding_1", 64'(outstanding), 64'd1);
    while (global_cycle < 64'd112) cyc();
    exp_q.push_back(12);
    fire(1'b0, 32'd0, 1'b1, 32'd5);
    chk("s1_outstanding_0", 64'(outstanding), 64'd0);
    chk("s1_count", 64'(lat_count), 64'd1);
    chk("s1_sum", lat_sum, 64'd12);
    chk("s1_min", 64'(lat_min), 64'd12);
    chk("s1_max", 64'(lat_max), 64'd12);
    cyc();
    chk("s1_pulse_end", 64'(last_valid), 64'd0);

    // Fill to DEPTH, then overflow and orphan.
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      fire(1'b1, 32'(i), 1'b0, 32'd0);
      if (i == DEPTH - 2) chk("s2_not_full", 64'(table_full), 64'd0);
      if (i == DEPTH - 1) begin
        chk("s2_full", 64'(table_full), 64'd1);
        chk("s2_no_overflow_yet", 64'(err_overflow), 64'd0);
      end
    end
    chk("s2_overflow", 64'(err_overflow), 64'd1);
    chk("s2_outstanding", 64'(outstanding), 64'd16);
    fire(1'b0, 32'd0, 1'b1, 32'd16);
    chk("s2_orphan", 64'(err_orphan), 64'd1);
    chk("s2_outstanding_after_orphan", 64'(outstanding), 64'd16);
    // Full table: same-cycle free does not admit the request (id 0 issued 18 cycles ago).
    exp_q.push_back(18);
    fire(1'b1, 32'd50, 1'b1, 32'd0);
    chk("s2_drop_despite_free", 64'(outstanding), 64'd15);
    chk("s2_not_full_after_free", 64'(table_full), 64'd0);

    // Same-cycle request and response never match each other.
    do_reset();
    fire(1'b1, 32'd7, 1'b1, 32'd7);
    chk("s3_orphan", 64'(err_orphan), 64'd1);
    chk("s3_outstanding", 64'(outstanding), 64'd1);
    idle(2);
    exp_q.push_back(3);
    fire(1'b0, 32'd0, 1'b1, 32'd7);
    chk("s3_outstanding_0", 64'(outstanding), 64'd0);
    chk("s3_count", 64'(lat_count), 64'd1);

    // Accumulation, then stat_clear.
    do_reset();
    do_lat(32'd1, 4);
    do_lat(32'd2, 9);
    do_lat(32'd3, 2);
    chk("s4_count", 64'(lat_count), 64'd3);
    chk("s4_sum", lat_sum, 64'd15);
    chk("s4_min", 64'(lat_min), 64'd2);
    chk("s4_max", 64'(lat_max), 64'd9);
    fire(1'b1, 32'd99, 1'b0, 32'd0);
    stat_clear = 1'b1;
    cyc();
    stat_clear = 1'b0;
    chk_stats_reset("s4_clear");
    chk("s4_clear_outstanding", 64'(outstanding), 64'd1);
    // Clear coinciding with a hit: last_latency updates, stats stay cleared.
    stat_clear = 1'b1;
    exp_q.push_back(2);
    fire(1'b0, 32'd0, 1'b1, 32'd99);
    stat_clear = 1'b0;
    chk("s4_clear_hit_last", 64'(last_latency), 64'd2);
    chk_stats_reset("s4_clear_hit");
    chk("s4_clear_hit_outstanding", 64'(outstanding), 64'd0);

    // Out-of-order responses, then reset mid-operation.
    do_reset();
    global_cycle = 64'd10;
    fire(1'b1, 32'd1, 1'b0, 32'd0);
    fire(1'b1, 32'd2, 1'b0, 32'd0);
    fire(1'b1, 32'd3, 1'b0, 32'd0);
    while (global_cycle < 64'd20) cyc();
    exp_q.push_back(8);
    fire(1'b0, 32'd0, 1'b1, 32'd3);
    exp_q.push_back(11);
    fire(1'b0, 32'd0, 1'b1, 32'd1);
    exp_q.push_back(11);
    fire(1'b0, 32'd0, 1'b1, 32'd2);
    chk("s5_count", 64'(lat_count), 64'd3);
    chk("s5_sum", lat_sum, 64'd30);
    chk("s5_min", 64'(lat_min), 64'd8);
    chk("s5_max", 64'(lat_max), 64'd11);
    fire(1'b1, 32'd4, 1'b0, 32'd0);
    fire(1'b1, 32'd5, 1'b0, 32'd0);
    chk("s5_outstanding_2", 64'(outstanding), 64'd2);
    reset = 1'b0;
    cyc();
    chk("s5_rst_outstanding", 64'(outstanding), 64'd0);
    chk_stats_reset("s5_rst");
    chk("s5_rst_last_latency", 64'(last_latency), 64'd0);
    reset = 1'b1;
    // Entries discarded by reset must not match later.
    fire(1'b0, 32'd0, 1'b1, 32'd4);
    chk("s5_post_rst_orphan", 64'(err_orphan), 64'd1);
    idle(2);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
